cpu_step_ctrl: RTL
==================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter HALT_CODE, default 32'h0000000D: halt when mem_800 equals this value.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable samples of step_btn required to accept a new level, range 2..65535.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 tick  input  1  one-cycle pulse at the CPU step rate; pulses never occur on consecutive cycles.
REQ-006 run_sw  input  1  1 = free-run, 0 = single-step mode; synchronised inside the block.
REQ-007 step_btn  input  1  raw, bouncy pushbutton; synchronised and debounced inside the block.
REQ-008 mem_800  input  32  CPU memory word monitored for the halt code.
REQ-009 cpu_ce  output  1  one-cycle clock-enable pulse that advances the pipeline one cycle.
REQ-010 halted  output  1  high while in HALT.
REQ-011 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALT.
REQ-012 cycle_count  output  32  number of cpu_ce pulses issued since reset.

Function
REQ-013 run_sw and step_btn each pass through a 2-flop synchroniser before use; this adds 2 cycles of latency.
REQ-014 Debounce: debounced step_btn changes level only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive clk cycles; any mismatch-free cycle clears the counter.
REQ-015 A step request is the single-cycle rising edge of debounced step_btn.
REQ-016 IDLE: if synchronised run_sw = 1, go to RUN; else a step request goes to STEP; otherwise stay.
REQ-017 RUN: cpu_ce = tick; if synchronised run_sw = 0, go to IDLE on the next cycle, with no further cpu_ce issued.
REQ-018 STEP: wait for the next tick, assert cpu_ce for that one cycle, then return to IDLE; exactly one cpu_ce is issued per step request.
REQ-019 Step requests in RUN or STEP are discarded and are not queued.
REQ-020 HALT detect: mem_800 is compared with HALT_CODE every cycle in IDLE, RUN and STEP; on a match, go to HALT on the next edge, with priority over every other transition.
REQ-021 When a halt match and a tick fall on the same cycle, cpu_ce is suppressed for that cycle.
REQ-022 HALT: cpu_ce = 0 and halted = 1; the state is held until reset_n is asserted, and run_sw, step_btn and mem_800 changes are ignored.
REQ-023 cpu_ce is combinational from state, tick and the halt match; it is glitch-free relative to clk because all of its inputs are registered.
REQ-024 cycle_count increments by 1 on each cycle that cpu_ce = 1, and wraps from 32'hFFFFFFFF to 0.

Reset
REQ-025 While reset_n = 0 at a clk edge, the following are cleared on that edge: state to IDLE, halted = 0, cycle_count = 0, synchronisers to 0, debounce counter to 0, debounced level to 0.
REQ-026 cpu_ce = 0 during every cycle in which reset_n = 0.
REQ-027 Reset asserted mid-operation (RUN, STEP or HALT) abandons any pending step; the first cpu_ce after release occurs no earlier than 3 cycles after release.

Configuration
REQ-028 Macro CPU_STEP_CTRL_CYCLE_COUNT_EN: when defined, cycle_count behaves as specified in REQ-024.
REQ-029 When the macro is undefined, cycle_count is tied to 32'h0, no counter flops are synthesised, and all other behaviour is unchanged.

Verification
REQ-030 Free-run: reset, run_sw = 1, tick every 4 cycles for 40 cycles -> 10 cpu_ce pulses (9 or 10 depending on synchroniser alignment; the bench checks the exact count from its own timing), state = 1, cycle_count matches the pulse count.
REQ-031 Single-step with bounce: run_sw = 0, step_btn toggling every 3 cycles for 12 cycles then held high for 20 cycles -> exactly 1 cpu_ce, aligned to the first tick after debounce, then state = 0.
REQ-032 Halt: in RUN, set mem_800 = 32'h0000000D on the same cycle as a tick -> no cpu_ce that cycle, state = 3 and halted = 1 next cycle; toggling run_sw and step_btn for 100 cycles -> no cpu_ce.
REQ-033 Reset out of HALT: reset_n = 0 for 1 cycle -> state = 0, halted = 0, cycle_count = 0; with mem_800 = 0, stepping resumes.
REQ-034 Wrap: with the counter force-preloaded to 32'hFFFFFFFF, issue one cpu_ce -> cycle_count = 0; with the macro undefined, cycle_count stays 0 throughout all scenarios.
REQ-035 Mode switch mid-step: step request in IDLE, then run_sw = 1 before the tick -> exactly one cpu_ce from STEP, then IDLE, then RUN.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_step_ctrl                                                   |
// | Purpose  : Run / single-step / halt controller producing the CPU           |
// |            clock-enable, with synchronised and debounced operator inputs.  |
// | Options  : CPU_STEP_CTRL_CYCLE_COUNT_EN enables the cpu_ce pulse counter;  |
// |            when undefined, cycle_count reads as zero.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module cpu_step_ctrl #(
  parameter logic [31:0] HALT_CODE       = 32'h0000000D,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [31:0] mem_800,
  output logic        cpu_ce,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_STEP  = 2'd2;
  localparam logic [1:0]  ST_HALT  = 2'd3;
  localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

  logic        run_meta_q, run_meta_d;
  logic        run_sync_q, run_sync_d;
  logic        btn_meta_q, btn_meta_d;
  logic        btn_sync_q, btn_sync_d;
  logic [15:0] db_cnt_q,   db_cnt_d;
  logic        db_lvl_q,   db_lvl_d;
  logic        db_prev_q,  db_prev_d;
  logic [1:0]  state_q,    state_d;

  logic        step_req;
  logic        halt_match;
  logic        ce_raw;

  always_comb begin
    run_meta_d = run_sw;
    run_sync_d = run_meta_q;
    btn_meta_d = step_btn;
    btn_sync_d = btn_meta_q;
  end

  // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    db_cnt_d  = 16'd0;
    db_lvl_d  = db_lvl_q;
    db_prev_d = db_lvl_q;
    if (btn_sync_q != db_lvl_q) begin
      if (db_cnt_q == DB_LIMIT - 16'd1) begin
        db_lvl_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  assign step_req   = db_lvl_q & ~db_prev_q;
  assign halt_match = (mem_800 == HALT_CODE) && (state_q != ST_HALT);

  always_comb begin
    state_d = state_q;
    ce_raw  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_sync_q) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        ce_raw = tick & run_sync_q;
        if (!run_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        ce_raw = tick;
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    // A halt match overrides every other transition and swallows a coincident tick.
    if (halt_match) begin
      state_d = ST_HALT;
      ce_raw  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_cnt_q   <= 16'd0;
      db_lvl_q   <= 1'b0;
      db_prev_q  <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      run_meta_q <= run_meta_d;
      run_sync_q <= run_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      db_cnt_q   <= db_cnt_d;
      db_lvl_q   <= db_lvl_d;
      db_prev_q  <= db_prev_d;
      state_q    <= state_d;
    end
  end

  assign cpu_ce = ce_raw & reset_n;
  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

`ifdef CPU_STEP_CTRL_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q + {31'd0, cpu_ce};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_count_q <= 32'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

`default_nettype wire
